exe_track_pipe: RTL
===================

# exe_track_pipe

Three-entry execute-stage tracking pipeline that produces the per-stage in-flight metadata (destination register, write enable, op type, load flag) consumed by the hazard detection unit. It also applies that unit's decisions: it inserts bubbles on `reg_DE_flush`, resolves `forward_ctrl_A/B` into operand data, and retires stage-3 results to register-file writeback. It sits between the ID/EXE boundary and the register file.

## Interface
- `XLEN`, default 32: data width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_ID`  in  1  ID holds a real instruction.
- `rdAddr_ID`  in  5  destination register of the ID instruction.
- `regWrite_ID`  in  1  ID instruction writes `rd`.
- `op_type_ID`  in  2  op type: 00 ALU, 01 memory, 10 multi-cycle; 11 is reserved and treated as 00.
- `ltype_ID`  in  1  the memory op is a load.
- `rs1Data_ID`, `rs2Data_ID`  in  XLEN  register-file read data.
- `stall`, `reg_DE_flush`  in  1  from the hazard detection unit.
- `forward_ctrl_A`, `forward_ctrl_B`  in  2  from the hazard detection unit: 0 = register file, 1/2/3 = stage E1/E2/E3.
- `alu_res_E1`  in  XLEN  combinational ALU result of E1.
- `lsu_rdata_E2`  in  XLEN  load data for E2.
- `mul_res_E3`  in  XLEN  multi-cycle result for E3.
- `rdAddr_out_EXE`  out  15  {E3,E2,E1} rd; E1 is in bits [4:0].
- `regWrite_out_EXE`  out  3  {E3,E2,E1}.
- `op_type_out_EXE`  out  6  {E3,E2,E1}.
- `ltype_out_EXE`  out  3  {E3,E2,E1}.
- `opA_E1`, `opB_E1`  out  XLEN  registered E1 operands.
- `wb_en`  out  1  writeback enable.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  XLEN  writeback data.

## Operation
- Each entry holds {valid, rd, regWrite, op_type, ltype, res}. A bubble is all fields 0.
- Every cycle E3 takes E2, E2 takes E1, and E1 takes the ID instruction. `stall` does not freeze E1–E3; it is used only to gate fetch/decode outside this block.
- E1 loads a bubble when `reg_DE_flush`=1, or when `stall`=1 (even with `reg_DE_flush`=0), or when `valid_ID`=0.
- When E1 loads a real instruction, it stores `regWrite_ID & valid_ID`. `opA_E1` captures `fwdA` and `opB_E1` captures `fwdB`.
- On a bubble, `opA_E1` and `opB_E1` hold their previous values.
- Forwarding is combinational: `fwdA` = mux(`forward_ctrl_A`: 0 `rs1Data_ID`, 1 val_E1, 2 val_E2, 3 val_E3); `fwdB` is the same with `forward_ctrl_B` and `rs2Data_ID`.
- Per-stage forward value:
  - val_E1 = `alu_res_E1`.
  - val_E2 = `lsu_rdata_E2` if E2 is a load (op 01 and ltype=1), else res_E2.
  - val_E3 = `mul_res_E3` if E3 op is 10, else res_E3.
- Result capture on advance:
  - res_E2 ← `alu_res_E1`.
  - res_E3 ← val_E2.
  - Multi-cycle results are not captured before E3.
- Writeback happens from E3 while it is resident: `wb_en` = valid_E3 & regWrite_E3 & (rd_E3≠0); `wb_rd` = rd_E3; `wb_data` = val_E3.
- The metadata outputs are direct register views, so no zeroing logic beyond the bubble encoding is needed.

## Timing
- Reset (async assert, synchronous deassert on the next clk edge): all entries become bubbles. All packed outputs are 0, `wb_en`=0, and `opA_E1`=`opB_E1`=0.
- Latency: an instruction accepted at edge N is in E1 during cycle N, E2 during N+1, E3 during N+2, and is written back in cycle N+2 (combinational `wb_*`).
- A bubble inserted at edge N propagates as E1→E2→E3 and never asserts `wb_en`.
- A `stall` pulse asserted in cycle N causes exactly one E1 bubble at edge N+1. Older stages are unaffected.
- `forward_ctrl` = 3 with E3 retiring in the same cycle forwards val_E3; the register file is not read-through.
- Reset asserted mid-stream discards all in-flight entries immediately, with no writeback.
- rd=0 entries still propagate and are visible on the outputs, but `wb_en` is 0 for them.

## Structure
- Shared package `exe_pkg`:
  - op_type constants OP_ALU=2'b00, OP_MEM=2'b01, OP_MUL=2'b10.
  - Stage-entry struct typedef and `EXE_DEPTH`=3.
  - Bubble constant.
- Sub-module `exe_fwd_mux`: one 4:1 XLEN operand mux, instantiated twice (A and B).
- Top level holds the three stage registers and the writeback logic.

## Test plan
- Reset: hold `rst_n`=0 with a valid ID ALU op rd=5 → after release, all outputs 0 until the first edge; after that edge, `rdAddr_out_EXE`[4:0]=5 and `regWrite_out_EXE`=3'b001.
- ALU chain: ALU rd=3 (`alu_res_E1`=0x10) then ALU with `forward_ctrl_A`=1 → `opA_E1`=0x10; two cycles later `wb_en`=1, `wb_rd`=3, `wb_data`=0x10.
- Load-use: load rd=7 in E1, `stall`=`reg_DE_flush`=1 for one cycle → E1 holds a bubble with rd=0, regWrite=0; the next cycle, `forward_ctrl_A`=2 selects `lsu_rdata_E2`=0xABCD into `opA_E1`.
- Multi-cycle: op 10 rd=9 reaches E3, `mul_res_E3`=0x55, `forward_ctrl_B`=3 → `opB_E1`=0x55, `wb_data`=0x55.
- rd=0: ALU rd=0 with regWrite=1 → it appears in the metadata outputs, `wb_en` stays 0 in E3.
- Mid-stream reset: three valid ops in flight, pulse `rst_n` low → all `regWrite_out_EXE`=0 immediately, and no `wb_en` pulse follows.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-stage tracking pipeline.
// Stage metadata is kept separate from the XLEN-wide result so the struct stays width-agnostic.
package exe_pkg;

    localparam int unsigned EXE_DEPTH = 3;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic [1:0] op_type;
        logic       ltype;
    } stage_meta_t;

    localparam stage_meta_t BUBBLE = '0;

    // Reserved encoding 2'b11 behaves exactly like an ALU op.
    function automatic logic [1:0] norm_op(input logic [1:0] op);
        return (op == 2'b11) ? OP_ALU : op;
    endfunction

endpackage

// File: rtl/exe_fwd_mux.sv
// 4:1 operand forwarding mux: register file or one of the three execute stages.
module exe_fwd_mux #(
    parameter int unsigned Width = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [Width-1:0] rf_i,
    input  logic [Width-1:0] e1_i,
    input  logic [Width-1:0] e2_i,
    input  logic [Width-1:0] e3_i,
    output logic [Width-1:0] out_o
);

    always_comb begin
        out_o = rf_i;
        unique case (sel_i)
            2'd0: out_o = rf_i;
            2'd1: out_o = e1_i;
            2'd2: out_o = e2_i;
            2'd3: out_o = e3_i;
            default: out_o = rf_i;
        endcase
    end

endmodule

// File: rtl/exe_track_pipe.sv
// Three-stage execute tracking pipeline: in-flight metadata for hazard detection,
// operand forwarding into E1, and writeback of the E3 result.
module exe_track_pipe
    import exe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_ID,
    input  logic [4:0]      rdAddr_ID,
    input  logic            regWrite_ID,
    input  logic [1:0]      op_type_ID,
    input  logic            ltype_ID,
    input  logic [XLEN-1:0] rs1Data_ID,
    input  logic [XLEN-1:0] rs2Data_ID,
    input  logic            stall,
    input  logic            reg_DE_flush,
    input  logic [1:0]      forward_ctrl_A,
    input  logic [1:0]      forward_ctrl_B,
    input  logic [XLEN-1:0] alu_res_E1,
    input  logic [XLEN-1:0] lsu_rdata_E2,
    input  logic [XLEN-1:0] mul_res_E3,
    output logic [14:0]     rdAddr_out_EXE,
    output logic [2:0]      regWrite_out_EXE,
    output logic [5:0]      op_type_out_EXE,
    output logic [2:0]      ltype_out_EXE,
    output logic [XLEN-1:0] opA_E1,
    output logic [XLEN-1:0] opB_E1,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    stage_meta_t e1_q, e2_q, e3_q, e1_d;
    // E1's result lives on alu_res_E1, so only E2/E3 need a stored result.
    logic [XLEN-1:0] res_e2_q, res_e3_q, res_e2_d;
    logic [XLEN-1:0] opa_q, opb_q;
    logic [XLEN-1:0] val_e2, val_e3, fwd_a, fwd_b;
    logic            e1_load;

    always_comb begin
        e1_load = valid_ID & ~stall & ~reg_DE_flush;
        e1_d    = BUBBLE;
        if (e1_load) begin
            e1_d.valid     = 1'b1;
            e1_d.rd        = rdAddr_ID;
            e1_d.reg_write = regWrite_ID & valid_ID;
            e1_d.op_type   = norm_op(op_type_ID);
            e1_d.ltype     = ltype_ID;
        end
    end

    always_comb begin
        val_e2 = ((e2_q.op_type == OP_MEM) && e2_q.ltype) ? lsu_rdata_E2 : res_e2_q;
        val_e3 = (e3_q.op_type == OP_MUL) ? mul_res_E3 : res_e3_q;
        // Bubbles carry a zero result so downstream stages stay all-zero.
        res_e2_d = e1_q.valid ? alu_res_E1 : '0;
    end

    exe_fwd_mux #(
        .Width (XLEN)
    ) u_fwd_a (
        .sel_i (forward_ctrl_A),
        .rf_i  (rs1Data_ID),
        .e1_i  (alu_res_E1),
        .e2_i  (val_e2),
        .e3_i  (val_e3),
        .out_o (fwd_a)
    );

    exe_fwd_mux #(
        .Width (XLEN)
    ) u_fwd_b (
        .sel_i (forward_ctrl_B),
        .rf_i  (rs2Data_ID),
        .e1_i  (alu_res_E1),
        .e2_i  (val_e2),
        .e3_i  (val_e3),
        .out_o (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_q     <= BUBBLE;
            e2_q     <= BUBBLE;
            e3_q     <= BUBBLE;
            res_e2_q <= '0;
            res_e3_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            e3_q     <= e2_q;
            e2_q     <= e1_q;
            e1_q     <= e1_d;
            res_e3_q <= val_e2;
            res_e2_q <= res_e2_d;
            if (e1_load) begin
                opa_q <= fwd_a;
                opb_q <= fwd_b;
            end
        end
    end

    always_comb begin
        rdAddr_out_EXE   = {e3_q.rd, e2_q.rd, e1_q.rd};
        regWrite_out_EXE = {e3_q.reg_write, e2_q.reg_write, e1_q.reg_write};
        op_type_out_EXE  = {e3_q.op_type, e2_q.op_type, e1_q.op_type};
        ltype_out_EXE    = {e3_q.ltype, e2_q.ltype, e1_q.ltype};
        opA_E1           = opa_q;
        opB_E1           = opb_q;
        wb_en            = e3_q.valid & e3_q.reg_write & (e3_q.rd != 5'd0);
        wb_rd            = e3_q.rd;
        wb_data          = val_e3;
    end

endmodule
